// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller slice.
// Holds the default line count, FSM state encoding and CP0 status bit positions.
// Optional build macro used by int_ctrl: INT_SYNC_EN.
package int_pkg;

   localparam int N_INT_DEF = 6;
   localparam int ID_W_DEF  = 3;

   localparam int IM_LSB  = 10;
   localparam int EXL_BIT = 1;
   localparam int IE_BIT  = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } int_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder for the interrupt controller.
// The highest set index wins; valid_o flags that any line is set.
module int_prio_enc
   import int_pkg::*;
#(
   parameter int N = N_INT_DEF,
   parameter int W = ID_W_DEF
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] id_o,
   output logic         valid_o
);

   // Scan upward so a later, higher-numbered hit overrides a lower one
   always_comb begin
      id_o    = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec_i[i]) begin
            id_o    = W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt source side of the CPU interrupt handshake.
// Latches rising edges of the external lines as pending, masks them with the
// CP0 status word and raises intr until the CPU acknowledges with inta; the
// controller then stays in service until excp_ret.
// Build option: define INT_SYNC_EN to pass irq_src through a 2-flop synchronizer
// (adds two cycles of latency); otherwise irq_src is taken as synchronous to clk.
module int_ctrl #(
   parameter int N_INT = int_pkg::N_INT_DEF,
   parameter int ID_W  = int_pkg::ID_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_INT-1:0] irq_src,
   input  logic [31:0]      status,
   input  logic             inta,
   input  logic             excp_ret,
   output logic             intr,
   output logic [N_INT-1:0] int_level,
   output logic [ID_W-1:0]  int_id,
   output logic             in_service
);

   import int_pkg::*;

   logic [N_INT-1:0] irq_s;
   logic [N_INT-1:0] src_q;
   logic [N_INT-1:0] rise;
   logic [N_INT-1:0] pending_q, pending_d;
   logic [N_INT-1:0] clr;
   logic [N_INT-1:0] mp;
   logic [N_INT-1:0] level_q, level_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [ID_W-1:0]  enc_id;
   logic             enc_valid;
   logic             eligible;
   logic             intr_q, intr_d;
   logic             insvc_q, insvc_d;
   int_state_e       state_q, state_d;
   logic             unused_status;

`ifdef INT_SYNC_EN
   logic [N_INT-1:0] sync1_q, sync2_q;

   // Two-flop synchronizer for lines coming from another clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_src;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_src;
`endif

   // src_q resets to zero so a line already high at reset release reads as a rising edge
   assign rise = irq_s & ~src_q;

   assign mp       = pending_q & status[IM_LSB +: N_INT];
   assign eligible = enc_valid & status[IE_BIT] & ~status[EXL_BIT];

   // Only IM, EXL and IE matter here; the rest of the status word is deliberately ignored
   assign unused_status = ^status;

   int_prio_enc #(
      .N (N_INT),
      .W (ID_W)
   ) u_prio (
      .vec_i   (mp),
      .id_o    (enc_id),
      .valid_o (enc_valid)
   );

   // State, pending set and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         src_q     <= '0;
         pending_q <= '0;
         level_q   <= '0;
         id_q      <= '0;
         intr_q    <= 1'b0;
         insvc_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= irq_s;
         pending_q <= pending_d;
         level_q   <= level_d;
         id_q      <= id_d;
         intr_q    <= intr_d;
         insvc_q   <= insvc_d;
      end
   end

   // Handshake FSM; level/id track the masked pending set except while a request is outstanding
   always_comb begin
      state_d = state_q;
      intr_d  = intr_q;
      insvc_d = insvc_q;
      level_d = mp;
      id_d    = enc_id;
      clr     = '0;
      case (state_q)
         IDLE: begin
            if (eligible) begin
               state_d = REQ;
               intr_d  = 1'b1;
            end
         end
         REQ: begin
            level_d = level_q;
            id_d    = id_q;
            if (inta) begin
               state_d = SERVICE;
               intr_d  = 1'b0;
               insvc_d = 1'b1;
               clr     = N_INT'(1) << id_q;
            end else if (!eligible) begin
               state_d = IDLE;
               intr_d  = 1'b0;
            end
         end
         SERVICE: begin
            if (excp_ret) begin
               state_d = IDLE;
               insvc_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            intr_d  = 1'b0;
            insvc_d = 1'b0;
         end
      endcase
      // A new edge on the acknowledged line survives the clear
      pending_d = (pending_q & ~clr) | rise;
   end

   assign intr       = intr_q;
   assign int_level  = level_q;
   assign int_id     = id_q;
   assign in_service = insvc_q;

endmodule
